// File: rtl/alu_op_sequencer.sv
// Command sequencer around the 10-bit signed ALU: registers operands on accept,
// captures the ALU result one cycle later and returns it through a show-ahead FIFO.
module alu_op_sequencer #(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 8
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_cmd_valid,
    output logic                    o_cmd_ready,
    input  logic [2:0]              i_cmd_oper,
    input  logic signed [9:0]       i_cmd_arg0,
    input  logic signed [9:0]       i_cmd_arg1,
    output logic signed [9:0]       o_alu_arg0,
    output logic signed [9:0]       o_alu_arg1,
    output logic [2:0]              o_alu_oper,
    input  logic signed [9:0]       i_alu_result,
    input  logic [3:0]              i_alu_flag,
    output logic                    o_rsp_valid,
    input  logic                    i_rsp_ready,
    output logic signed [9:0]       o_rsp_result,
    output logic [3:0]              o_rsp_flag,
    output logic                    o_ovf_sticky,
    input  logic                    i_ovf_clear,
    output logic [CNT_W-1:0]        o_cmd_count
);

    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int FCNT_W = PTR_W + 1;

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_t;

    state_t              state, state_nxt;
    logic                accept;
    logic                capture;
    logic                pop;
    logic [PTR_W-1:0]    wr_ptr, rd_ptr;
    logic [FCNT_W-1:0]   fifo_count;
    logic [13:0]         fifo_mem [FIFO_DEPTH];
    logic [13:0]         head;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        o_cmd_ready = 1'b0;
        accept      = 1'b0;
        capture     = 1'b0;
        case (state)
            IDLE: begin
                o_cmd_ready = (fifo_count < FCNT_W'(FIFO_DEPTH));
                if (i_cmd_valid && o_cmd_ready) begin
                    accept    = 1'b1;
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                capture   = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand stage: ALU inputs change only when a command is accepted
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_alu_arg0 <= '0;
            o_alu_arg1 <= '0;
            o_alu_oper <= '0;
        end else if (accept) begin
            o_alu_arg0 <= i_cmd_arg0;
            o_alu_arg1 <= i_cmd_arg1;
            o_alu_oper <= i_cmd_oper;
        end
    end

    // Capture stage: ALU output lands in the response FIFO
    always_ff @(posedge i_clk) begin
        if (capture) fifo_mem[wr_ptr] <= {i_alu_flag, i_alu_result};
    end

    assign o_rsp_valid = (fifo_count != '0);
    assign pop         = o_rsp_valid & i_rsp_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (capture) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({capture, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Memory is not reset, so the head is masked to zero while empty
    assign head         = fifo_mem[rd_ptr];
    assign o_rsp_result = o_rsp_valid ? $signed(head[9:0]) : '0;
    assign o_rsp_flag   = o_rsp_valid ? head[13:10] : '0;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_ovf_sticky <= 1'b0;
            o_cmd_count  <= '0;
        end else begin
            if (capture && i_alu_flag[0]) o_ovf_sticky <= 1'b1;
            else if (i_ovf_clear)         o_ovf_sticky <= 1'b0;
            if (capture) o_cmd_count <= o_cmd_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: behavioural ALU, queue-based response model,
// directed scenarios plus a randomized stream.
module tb_alu_op_sequencer;

    localparam int DEPTH = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [2:0]        cmd_oper;
    logic signed [9:0] cmd_arg0, cmd_arg1;
    logic signed [9:0] dut_arg0, dut_arg1;
    logic [2:0]        dut_oper;
    logic [13:0]       alu_bus;
    logic [9:0]        alu_res;
    logic [3:0]        alu_flag;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [9:0]        rsp_result;
    logic [3:0]        rsp_flag;
    logic              ovf_sticky;
    logic              ovf_clear;
    logic [7:0]        cmd_count;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [9:0]  q_res[$];
    logic [3:0]  q_flag[$];
    bit          m_busy;
    logic [13:0] m_pend;
    int          m_cnt;
    bit          m_sticky;
    bit          last_acc;
    int          cyc = 0;
    int          acc_cyc;

    always #5 clk = ~clk;

    // Behavioural ALU: {NEG, POS, ZERO, OVF, result}
    function automatic logic [13:0] alu_ref(input logic [2:0] op, input int a, input int b);
        int         r;
        logic [9:0] av, bv, res;
        logic       ovf, neg, zero, pos;
        r   = 0;
        av  = a[9:0];
        bv  = b[9:0];
        ovf = 1'b0;
        res = '0;
        case (op)
            3'd0: begin r = a + b; res = r[9:0]; ovf = (r > 511) || (r < -512); end
            3'd1: begin r = a - b; res = r[9:0]; ovf = (r > 511) || (r < -512); end
            3'd2: begin r = (a > b) ? a : b; res = r[9:0]; end
            3'd3: begin r = (a < b) ? a : b; res = r[9:0]; end
            3'd4: res = av & bv;
            3'd5: res = av | bv;
            3'd6: res = av ^ bv;
            default: res = ~(av ^ bv);
        endcase
        neg  = res[9];
        zero = (res == 10'd0);
        pos  = !neg && !zero;
        return {neg, pos, zero, ovf, res};
    endfunction

    assign alu_bus  = alu_ref(dut_oper, int'(dut_arg0), int'(dut_arg1));
    assign alu_res  = alu_bus[9:0];
    assign alu_flag = alu_bus[13:10];

    alu_op_sequencer #(.FIFO_DEPTH(DEPTH), .CNT_W(8)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_cmd_valid  (cmd_valid),
        .o_cmd_ready  (cmd_ready),
        .i_cmd_oper   (cmd_oper),
        .i_cmd_arg0   (cmd_arg0),
        .i_cmd_arg1   (cmd_arg1),
        .o_alu_arg0   (dut_arg0),
        .o_alu_arg1   (dut_arg1),
        .o_alu_oper   (dut_oper),
        .i_alu_result (alu_res),
        .i_alu_flag   (alu_flag),
        .o_rsp_valid  (rsp_valid),
        .i_rsp_ready  (rsp_ready),
        .o_rsp_result (rsp_result),
        .o_rsp_flag   (rsp_flag),
        .o_ovf_sticky (ovf_sticky),
        .i_ovf_clear  (ovf_clear),
        .o_cmd_count  (cmd_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: check pre-edge outputs, advance, update model, check post-edge state
    task automatic cycle();
        bit exp_ready, do_acc, do_pop, cap, clr;
        exp_ready = !m_busy && (q_res.size() < DEPTH);
        chk("cmd_ready", cmd_ready, exp_ready);
        chk("rsp_valid", rsp_valid, q_res.size() != 0);
        if (q_res.size() != 0) begin
            chk("rsp_result", rsp_result, q_res[0]);
            chk("rsp_flag", rsp_flag, q_flag[0]);
        end
        do_acc = cmd_valid && exp_ready;
        do_pop = (q_res.size() != 0) && rsp_ready;
        cap    = m_busy;
        clr    = ovf_clear;
        @(posedge clk);
        #1;
        cyc++;
        if (do_pop) begin
            void'(q_res.pop_front());
            void'(q_flag.pop_front());
        end
        if (cap) begin
            q_res.push_back(m_pend[9:0]);
            q_flag.push_back(m_pend[13:10]);
            m_cnt  = (m_cnt + 1) % 256;
            m_busy = 1'b0;
            if (m_pend[10])  m_sticky = 1'b1;
            else if (clr)    m_sticky = 1'b0;
        end else if (clr) begin
            m_sticky = 1'b0;
        end
        last_acc = do_acc;
        if (do_acc) begin
            m_busy  = 1'b1;
            m_pend  = alu_ref(cmd_oper, int'(cmd_arg0), int'(cmd_arg1));
            acc_cyc = cyc;
            chk("alu_oper", dut_oper, cmd_oper);
            chk("alu_arg0", dut_arg0, cmd_arg0);
            chk("alu_arg1", dut_arg1, cmd_arg1);
        end
        chk("ovf_sticky", ovf_sticky, m_sticky);
        chk("cmd_count", cmd_count, m_cnt);
    endtask

    task automatic send_cmd(input logic [2:0] op, input logic signed [9:0] a, input logic signed [9:0] b);
        cmd_oper  = op;
        cmd_arg0  = a;
        cmd_arg1  = b;
        cmd_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (last_acc) break;
        end
        chk("accept_timeout", last_acc, 1'b1);
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        rsp_ready = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if (q_res.size() == 0 && !m_busy) break;
            cycle();
        end
        rsp_ready = 1'b0;
        chk("drained", rsp_valid, 1'b0);
    endtask

    // Asserted away from any clock edge; outputs checked before the next edge
    task automatic do_reset();
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        ovf_clear = 1'b0;
        #1;
        q_res.delete();
        q_flag.delete();
        m_busy   = 1'b0;
        m_cnt    = 0;
        m_sticky = 1'b0;
        chk("rst_cmd_ready", cmd_ready, 1'b1);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_result", rsp_result, 10'd0);
        chk("rst_rsp_flag", rsp_flag, 4'd0);
        chk("rst_alu_arg0", dut_arg0, 10'd0);
        chk("rst_alu_arg1", dut_arg1, 10'd0);
        chk("rst_alu_oper", dut_oper, 3'd0);
        chk("rst_sticky", ovf_sticky, 1'b0);
        chk("rst_count", cmd_count, 8'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int a1, a2, a3;
        logic [9:0] e_res [3];
        logic [3:0] e_flag [3];
        e_res  = '{10'h000, 10'h003, 10'h3FF};
        e_flag = '{4'b0010, 4'b0100, 4'b1000};

        rst_n     = 1'b1;
        cmd_valid = 1'b0;
        cmd_oper  = '0;
        cmd_arg0  = '0;
        cmd_arg1  = '0;
        rsp_ready = 1'b0;
        ovf_clear = 1'b0;
        m_busy    = 1'b0;
        m_pend    = '0;
        m_cnt     = 0;
        m_sticky  = 1'b0;
        last_acc  = 1'b0;
        acc_cyc   = 0;
        #2;
        do_reset();

        // ADD 300+300 wraps to -424 with NEG and OVF
        send_cmd(3'd0, 10'sd300, 10'sd300);
        cycle();
        chk("add_result", rsp_result, 10'h258);
        chk("add_flag", rsp_flag, 4'b1001);
        chk("add_sticky", ovf_sticky, 1'b1);
        chk("add_count", cmd_count, 8'd1);
        drain();

        // Back-to-back SUB, MAX, XNOR
        send_cmd(3'd1, 10'sd5, 10'sd5);
        a1 = acc_cyc;
        send_cmd(3'd2, -10'sd5, 10'sd3);
        a2 = acc_cyc;
        send_cmd(3'd7, 10'sd0, 10'sd0);
        a3 = acc_cyc;
        cycle();
        chk("b2b_spacing1", a2 - a1, 2);
        chk("b2b_spacing2", a3 - a2, 2);
        for (int i = 0; i < 3; i++) begin
            chk("b2b_result", rsp_result, e_res[i]);
            chk("b2b_flag", rsp_flag, e_flag[i]);
            rsp_ready = 1'b1;
            cycle();
            rsp_ready = 1'b0;
        end
        chk("b2b_empty", rsp_valid, 1'b0);

        // Fill the FIFO, then a fifth command must wait for a pop
        for (int i = 0; i < DEPTH; i++)
            send_cmd(3'(i), 10'(i * 17 - 30), 10'(100 - i * 45));
        cmd_oper  = 3'd6;
        cmd_arg0  = 10'sd123;
        cmd_arg1  = -10'sd77;
        cmd_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("full_no_accept", last_acc, 1'b0);
        end
        chk("full_ready_low", cmd_ready, 1'b0);
        rsp_ready = 1'b1;
        cycle();
        rsp_ready = 1'b0;
        chk("ready_after_pop", cmd_ready, 1'b1);
        cycle();
        chk("fifth_accepted", last_acc, 1'b1);
        cmd_valid = 1'b0;
        cycle();
        drain();

        // Randomized stream with the consumer always ready
        rsp_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            send_cmd(3'($urandom_range(7, 0)), 10'($urandom), 10'($urandom));
            rsp_ready = 1'b1;
        end
        drain();

        // Sticky overflow: set beats clear on the same edge
        ovf_clear = 1'b1;
        cycle();
        ovf_clear = 1'b0;
        chk("sticky_cleared", ovf_sticky, 1'b0);
        send_cmd(3'd0, 10'sd511, 10'sd1);
        cycle();
        chk("sticky_set", ovf_sticky, 1'b1);
        send_cmd(3'd0, 10'sd511, 10'sd511);
        ovf_clear = 1'b1;
        cycle();
        ovf_clear = 1'b0;
        chk("sticky_set_wins", ovf_sticky, 1'b1);
        send_cmd(3'd0, 10'sd1, 10'sd1);
        cycle();
        ovf_clear = 1'b1;
        cycle();
        ovf_clear = 1'b0;
        chk("sticky_late_clear", ovf_sticky, 1'b0);
        drain();

        // Reset during EXEC with two responses queued
        send_cmd(3'd5, 10'sd12, 10'sd3);
        send_cmd(3'd3, -10'sd100, 10'sd7);
        cycle();
        send_cmd(3'd0, 10'sd1, 10'sd2);
        chk("exec_busy_ready", cmd_ready, 1'b0);
        do_reset();
        rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) cycle();
        rsp_ready = 1'b0;
        chk("post_rst_valid", rsp_valid, 1'b0);
        chk("post_rst_count", cmd_count, 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Command sequencer that wraps the 10-bit signed ALU stage. It accepts operation commands over a valid/ready interface and drives the ALU operand and opcode inputs from registers. It captures the ALU's combinational result and flags, then returns them through a small response FIFO with its own valid/ready handshake. It also keeps a sticky overflow indicator and a command counter for the host.

## Interface

- FIFO_DEPTH, 4, response FIFO entries; power of two, 2..16
- CNT_W, 8, width of command counter
- i_clk  in  1  single clock, rising edge
- i_rst_n  in  1  reset, asynchronous, active-low
- i_cmd_valid  in  1  command present
- o_cmd_ready  out  1  sequencer can accept a command
- i_cmd_oper  in  3  opcode: 0 ADD, 1 SUB, 2 MAX, 3 MIN, 4 AND, 5 OR, 6 XOR, 7 XNOR
- i_cmd_arg0  in  10  signed operand 0
- i_cmd_arg1  in  10  signed operand 1
- o_alu_arg0  out  10  registered operand 0 to ALU
- o_alu_arg1  out  10  registered operand 1 to ALU
- o_alu_oper  out  3  registered opcode to ALU
- i_alu_result  in  10  ALU result (combinational from o_alu_*)
- i_alu_flag  in  4  ALU flags {NEG, POS, ZERO, OVF}
- o_rsp_valid  out  1  FIFO head valid
- i_rsp_ready  in  1  consumer takes head
- o_rsp_result  out  10  head result
- o_rsp_flag  out  4  head flags
- o_ovf_sticky  out  1  set by any captured OVF
- i_ovf_clear  in  1  synchronous clear of o_ovf_sticky
- o_cmd_count  out  CNT_W  number of completed commands, wrapping

## Operation

- FSM states are IDLE and EXEC. Reset enters IDLE.
- IDLE: o_cmd_ready = (fifo_count < FIFO_DEPTH).
  - On i_cmd_valid & o_cmd_ready, i_cmd_oper/arg0/arg1 load into o_alu_oper/arg0/arg1.
  - The FSM then moves to EXEC.
- EXEC: o_cmd_ready = 0. At the closing edge:
  - i_alu_result and i_alu_flag are pushed into the FIFO.
  - o_cmd_count increments, wrapping from 2^CNT_W-1 to 0.
  - o_ovf_sticky sets if i_alu_flag[0] = 1.
  - The FSM returns to IDLE.
- o_alu_* hold their last values in IDLE; they change only on accept.
- FIFO is show-ahead: o_rsp_valid = (fifo_count != 0); o_rsp_result/o_rsp_flag show the head entry.
  - A pop occurs on o_rsp_valid & i_rsp_ready.
- A push and a pop in the same cycle leave fifo_count unchanged, and ordering is preserved.
- The FIFO can never overflow: a command is accepted only if space exists, and at most one command is in flight.
- Read and write pointers wrap modulo FIFO_DEPTH.
- o_ovf_sticky: clear on i_ovf_clear. If a set and a clear land in the same cycle, the set wins.
- No arithmetic in this block. Result and flags pass bit-exact from the ALU.

## Timing

- Reset (i_rst_n low, asynchronous) forces, regardless of i_clk:
  - FSM to IDLE and FIFO empty.
  - o_alu_arg0 = 0, o_alu_arg1 = 0, o_alu_oper = 0.
  - o_rsp_valid = 0, o_rsp_result = 0, o_rsp_flag = 0.
  - o_ovf_sticky = 0 and o_cmd_count = 0.
  - o_cmd_ready = 1, since the FSM is in IDLE with an empty FIFO.
- Reset release is synchronous to i_clk at the consuming flops. The first accept is possible on the first rising edge after release.
- Accept at edge k:
  - o_alu_* are valid after edge k.
  - Capture happens at edge k+1.
  - o_rsp_valid is high after edge k+1 if the FIFO was empty.
- Throughput is one command per 2 cycles.
- o_cmd_ready is high again after edge k+1, provided fifo_count < FIFO_DEPTH.
- When full, o_cmd_ready stays low until the cycle after a pop.
- Reset asserted during EXEC: the in-flight command is discarded and not counted, and all FIFO contents are lost.
- i_cmd_* are sampled only on handshake. Changes to them while o_cmd_ready is low are ignored.

## Test plan

- Reset, then ADD 300+300 → after 2 edges o_rsp_result = -424 (0x258), o_rsp_flag = 4'b1001, o_ovf_sticky = 1, o_cmd_count = 1.
- SUB 5-5, then MAX -5,3, then XNOR 0,0 back-to-back → results 0/flag 0010, 3/flag 0100, -1/flag 1000, in order. Accepts occur every 2nd cycle.
- Hold i_rsp_ready = 0 and send 5 commands (FIFO_DEPTH = 4) → the 4 accept, and o_cmd_ready stays 0 for the 5th. A single pop re-enables ready, and the 5th result lands at the tail.
- Hold i_rsp_ready = 1 while streaming 10 commands → each response pops the cycle it appears, count never exceeds 1, and there is no loss or duplication.
- Sticky: ADD 511+1 (OVF), then assert i_ovf_clear on the same edge as the capture of a second overflowing ADD → sticky stays 1. A later clear with no OVF → 0.
- Assert i_rst_n low during EXEC with 2 entries queued → all outputs go to reset values immediately. The aborted command never appears, and o_cmd_count = 0.
